// File: rtl/mem_access.sv
// Memory-stage load/store unit: alignment checks, store lane replication,
// load extension and a one-outstanding request/response handshake FSM.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        memenM,
    input  logic [2:0]  memopM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    input  logic        advanceM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DONE, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata;
    logic        w_store;
    logic        w_misalign;
    logic        w_go;
    logic [31:0] w_src;

    function automatic logic [1:0] f_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: f_size = 2'd0;
            3'd2, 3'd3, 3'd6: f_size = 2'd1;
            default:          f_size = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic signed [7:0]  v_b;
        logic signed [15:0] v_h;
        v_b = word[{lane, 3'b000} +: 8];
        v_h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            3'd0:    f_extend = {{24{v_b[7]}}, v_b};
            3'd1:    f_extend = {24'h0, v_b};
            3'd2:    f_extend = {{16{v_h[15]}}, v_h};
            3'd3:    f_extend = {16'h0, v_h};
            default: f_extend = word;
        endcase
    endfunction

    assign w_store    = memopM[2] & (memopM[1] | memopM[0]);
    assign data_size  = f_size(memopM);
    assign w_misalign = (data_size == 2'd1 && aluoutM[0]) ||
                        (data_size == 2'd2 && aluoutM[1:0] != 2'b00);
    assign adelM      = memenM & ~w_store & w_misalign;
    assign adesM      = memenM & w_store & w_misalign;
    assign w_go       = memenM & ~w_misalign & ~flushM;
    assign badvaddrM  = aluoutM;
    assign data_addr  = aluoutM;
    assign data_wr    = w_store;

    always_comb begin
        case (data_size)
            2'd0:    data_wdata = {4{writedataM[7:0]}};
            2'd1:    data_wdata = {2{writedataM[15:0]}};
            default: data_wdata = writedataM;
        endcase
    end

    // The raw bus word is only visible while data_ok is high, so DONE replays the latched copy.
    assign w_src     = (r_state == S_DONE) ? r_rdata : data_rdata;
    assign readdataM = (r_state == S_DATA || r_state == S_DONE) ?
                       f_extend(memopM, aluoutM[1:0], w_src) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DATA && data_data_ok)
                r_rdata <= data_rdata;
        end
    end

    always_comb begin
        w_next   = r_state;
        data_req = 1'b0;
        stallM   = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_req = w_go;
                stallM   = w_go;
                if (w_go && data_addr_ok)
                    w_next = S_DATA;
            end
            S_DATA: begin
                stallM = ~data_data_ok;
                if (data_data_ok)
                    w_next = (advanceM || flushM) ? S_IDLE : S_DONE;
                else if (flushM)
                    w_next = S_DRAIN;
            end
            S_DONE: begin
                if (advanceM || flushM)
                    w_next = S_IDLE;
            end
            S_DRAIN: begin
                stallM = 1'b1;
                if (data_data_ok)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: byte-addressed reference memory, a
// word-wide bus model with random latency, and queue-based scoreboards.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        memenM;
    logic [2:0]  memopM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        advanceM;
    logic        hold;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badvaddrM;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset), .memenM(memenM), .memopM(memopM),
        .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM),
        .advanceM(advanceM), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .readdataM(readdataM), .stallM(stallM),
        .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM)
    );

    // Pipeline advances whenever the unit is not stalling and the rest of the pipe is not holding.
    assign advanceM = ~stallM & ~hold;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        q_req[$];
    logic [31:0] q_ld[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] bus_mem [64];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_on = 1'b0;
    bit          aborted = 1'b0;
    bit          bus_pend = 1'b0;
    int          bus_cnt = 0;
    logic [31:0] bus_resp = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name, input string detail);
        n_chk++;
        $display("FAIL %s: %s", name, detail);
    endtask

    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input logic [2:0] op);
        int n;
        n = size_of(op);
        return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic bit is_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic bit misal(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % size_of(op)) != 0;
    endfunction

    // Bus side: grant requests at random while idle, answer after 1..4 cycles.
    always @(negedge clk) begin
        if (bus_pend && bus_cnt == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = bus_resp;
            data_addr_ok = 1'b0;
        end else begin
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            data_addr_ok = !bus_pend && ($urandom % 3 != 0);
        end
    end

    // Monitor: one cycle-end sample, just before the rising edge.
    always @(negedge clk) begin : monitor
        bit          pend_was;
        bit          m;
        bit          st;
        req_t        e;
        logic [31:0] exp_ld;
        int          idx;
        int          off;
        int          nb;
        #4;
        if (mon_on) begin
            pend_was = bus_pend;
            if (pend_was) chk("req_while_busy", data_req, 1'b0);
            if (data_req && data_addr_ok) begin
                if (q_req.size() == 0) begin
                    fail_now("req_unexpected", $sformatf("got request addr %h, expected none", data_addr));
                end else begin
                    e = q_req.pop_front();
                    chk("req_wr", data_wr, e.wr);
                    chk("req_size", data_size, e.size);
                    chk("req_addr", data_addr, e.addr);
                    if (e.wr) chk("req_wdata", data_wdata, e.wdata);
                end
                idx = int'(data_addr[7:2]);
                off = int'(data_addr[1:0]);
                nb  = 1 << data_size;
                if (data_wr) begin
                    for (int l = 0; l < 4; l++)
                        if (l >= off && l < off + nb) bus_mem[idx][8*l +: 8] = data_wdata[8*l +: 8];
                end else begin
                    bus_resp = bus_mem[idx];
                end
                bus_pend = 1'b1;
                bus_cnt  = $urandom % 4;
            end else if (pend_was) begin
                if (data_data_ok) bus_pend = 1'b0;
                else if (bus_cnt > 0) bus_cnt--;
            end

            m  = misal(memopM, aluoutM);
            st = is_store(memopM);
            if (memenM) begin
                chk("adelM", adelM, m && !st);
                chk("adesM", adesM, m && st);
                if (m) begin
                    chk("badvaddrM", badvaddrM, aluoutM);
                    if (!pend_was) chk("misalign_stall", stallM, 1'b0);
                end
            end else begin
                chk("no_fault_idle", {adelM, adesM}, 2'b00);
            end
            if (!memenM || flushM || (memenM && m)) chk("req_suppressed", data_req, 1'b0);

            if (memenM && !st && !m && (flushM || advanceM)) begin
                if (q_ld.size() == 0) begin
                    fail_now("load_unexpected", $sformatf("got load retire %h, expected none", readdataM));
                end else begin
                    exp_ld = q_ld.pop_front();
                    if (!flushM) chk("readdataM", readdataM, exp_ld);
                end
            end
        end
    end

    // Present one M-stage instruction at a falling edge and hold it until it retires.
    // mode 0: normal, mode 1: flushed on its first cycle, mode 2: load flushed k+1 cycles after acceptance.
    task automatic run_instr(input bit en, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input int mode, input int k);
        bit          m;
        bit          st;
        bit          acc;
        bit          retire;
        int          since;
        int          a;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] v;
        if (aborted) return;
        memenM = en; memopM = op; aluoutM = addr; writedataM = wd;
        m  = misal(op, addr);
        st = is_store(op);
        a  = int'(addr[7:0]);
        if (en && !m) begin
            if (!st) begin
                b0 = ref_mem[a]; b1 = ref_mem[(a + 1) & 255];
                b2 = ref_mem[(a + 2) & 255]; b3 = ref_mem[(a + 3) & 255];
                case (op)
                    3'd0:    v = {{24{b0[7]}}, b0};
                    3'd1:    v = {24'h0, b0};
                    3'd2:    v = {{16{b1[7]}}, b1, b0};
                    3'd3:    v = {16'h0, b1, b0};
                    default: v = {b3, b2, b1, b0};
                endcase
                q_ld.push_back(v);
                if (mode != 1) q_req.push_back('{1'b0, size_code(op), addr, 32'h0});
            end else if (mode != 1) begin
                for (int i = 0; i < size_of(op); i++) ref_mem[(a + i) & 255] = wd[8*i +: 8];
                case (size_of(op))
                    1:       v = wd[7:0] * 32'h0101_0101;
                    2:       v = wd[15:0] * 32'h0001_0001;
                    default: v = wd;
                endcase
                q_req.push_back('{1'b1, size_code(op), addr, v});
            end
        end
        acc = 1'b0;
        since = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            flushM = (mode == 1 && cyc == 0) || (mode == 2 && acc && since == k);
            hold   = ($urandom % 4 == 0);
            #4;
            retire = flushM || advanceM;
            if (acc) since++;
            else if (data_req && data_addr_ok) acc = 1'b1;
            @(negedge clk);
            if (retire) begin
                flushM = 1'b0;
                return;
            end
        end
        fail_now("instr_timeout", $sformatf("got no retire of op %0d addr %h in 200 cycles, expected retire", op, addr));
        aborted = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        int          mode;
        logic [2:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            bus_mem[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
        end
        bus_mem[0] = 32'h8765_4321;
        ref_mem[0] = 8'h21; ref_mem[1] = 8'h43; ref_mem[2] = 8'h65; ref_mem[3] = 8'h87;

        reset = 1'b1; memenM = 1'b0; memopM = 3'd0; aluoutM = 32'h0;
        writedataM = 32'h0; flushM = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #4;
        chk("rst_data_req", data_req, 1'b0);
        chk("rst_stallM", stallM, 1'b0);
        chk("rst_adelM", adelM, 1'b0);
        chk("rst_adesM", adesM, 1'b0);
        chk("rst_readdataM", readdataM, 32'h0);
        mon_on = 1'b1;
        @(negedge clk);

        run_instr(1, 3'd4, 32'h0000_0100, 32'h0, 0, 0);
        run_instr(1, 3'd7, 32'h0000_0100, 32'h80FF_FFFF, 0, 0);
        run_instr(1, 3'd0, 32'h0000_0103, 32'h0, 0, 0);
        run_instr(1, 3'd1, 32'h0000_0103, 32'h0, 0, 0);
        run_instr(1, 3'd3, 32'h0000_0102, 32'h0, 0, 0);
        run_instr(1, 3'd6, 32'h0000_0206, 32'h1234_ABCD, 0, 0);
        run_instr(1, 3'd5, 32'h0000_0201, 32'h1234_ABCD, 0, 0);
        run_instr(1, 3'd4, 32'h0000_0102, 32'h0, 0, 0);
        run_instr(1, 3'd7, 32'h0000_0101, 32'h5555_5555, 0, 0);
        run_instr(1, 3'd4, 32'h0000_0100, 32'h0, 2, 2);
        run_instr(1, 3'd4, 32'h0000_0104, 32'h0, 0, 0);
        run_instr(1, 3'd2, 32'h0000_0104, 32'h0, 1, 0);

        for (int n = 0; n < 400 && !aborted; n++) begin
            op   = 3'($urandom % 8);
            addr = ($urandom & 32'hF000_0000) | ($urandom & 32'hFF);
            if ($urandom % 5 != 0) addr = addr & ~32'(size_of(op) - 1);
            r    = $urandom % 10;
            mode = (r < 7) ? 0 : (r == 7) ? 1 : (is_store(op) ? 0 : 2);
            run_instr($urandom % 5 != 0, op, addr, $urandom, mode, $urandom % 4);
        end

        memenM = 1'b0; flushM = 1'b0; hold = 1'b0;
        repeat (12) @(negedge clk);
        #4;
        chk("req_queue_empty", q_req.size(), 0);
        chk("load_queue_empty", q_ld.size(), 0);
        chk("bus_idle", bus_pend, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data access unit for the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes the M-stage access signals: enable, operation, address and store data. It drives a split address/data handshake to the data SRAM-like bus, checks alignment, aligns store data, and sign- or zero-extends load data. It stalls the pipeline until each access completes and tolerates flushes while a request is outstanding.

## Interface
Parameters: none.
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- memenM  input  1  M-stage instruction is a load/store
- memopM  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- aluoutM  input  32  effective byte address
- writedataM  input  32  store source register value
- flushM  input  1  exception/redirect; kill current M instruction
- advanceM  input  1  M stage advances at this edge (global stall logic result)
- data_req  output  1  request valid
- data_wr  output  1  1 = store
- data_size  output  2  0 byte, 1 half, 2 word
- data_addr  output  32  byte address (= aluoutM)
- data_wdata  output  32  lane-replicated store data
- data_addr_ok  input  1  request accepted this cycle
- data_data_ok  input  1  response/write-ack this cycle
- data_rdata  input  32  raw read word
- readdataM  output  32  extended load result
- stallM  output  1  hold the pipeline at and before M
- adelM, adesM  output  1 each  misaligned load / misaligned store
- badvaddrM  output  32  faulting address (= aluoutM)

## Operation
- Alignment: half requires aluoutM[0]=0; word requires aluoutM[1:0]=0. Byte accesses are always aligned.
- Alignment flags: adelM = memenM & load & misaligned; adesM = memenM & store & misaligned. Both are combinational.
- go = memenM & ~adelM & ~adesM & ~flushM.
- Store data: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
- Load extraction, little-endian:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Source is data_rdata in state DATA; the latched word in DONE.
- FSM states and transitions:
  - IDLE: data_req = go. go & addr_ok -> DATA; otherwise stay in IDLE.
  - DATA: data_req = 0; waits for data_ok.
    - data_ok & (advanceM | flushM) -> IDLE.
    - data_ok & ~advanceM & ~flushM -> DONE, latching data_rdata.
    - ~data_ok & flushM -> DRAIN.
  - DONE: data_req = 0; readdataM comes from the latch. advanceM | flushM -> IDLE.
  - DRAIN: data_req = 0; the response is discarded. data_ok -> IDLE.
- stallM = (IDLE & go) | (DATA & ~data_ok) | DRAIN.
- data_wr, data_size, data_addr and data_wdata are combinational from the M inputs. They are meaningful only while data_req=1.
- At most one outstanding request at any time.

## Timing
- Reset: state IDLE, latch 0. With memenM=0 every output is 0: data_req, stallM, adelM, adesM, readdataM.
- Request handshake: data_req stays high and the request fields stay stable until addr_ok is sampled high. The M inputs are stable because stallM=1.
- Bus guarantee: data_ok never arrives in the same cycle as its addr_ok.
- Minimum access: request cycle N (addr_ok=1), data_ok in cycle N+1.
  - readdataM is valid in N+1; stallM=0 in N+1.
  - Total stall is 1 cycle.
- Flush in IDLE suppresses data_req in that same cycle, so no request is issued.
- Flush after acceptance goes through DRAIN. The following instruction's request is not issued until data_ok has been absorbed.
- A misaligned access raises no request and no stall. The flag is valid in the same cycle.

## Test plan
- LW at 0x100; addr_ok in cycle 0, data_ok in cycle 2 with rdata 0x8765_4321 -> stallM=1 in cycles 0–1, readdataM=0x8765_4321 in cycle 2.
- LB at addr 0x103 with rdata 0x80FF_FFFF -> readdataM=0xFFFF_FF80. LBU -> 0x0000_0080. LHU at 0x102 -> 0x0000_80FF.
- SH at 0x206 with wd 0x1234_ABCD -> data_wr=1, size=1, wdata=0xABCD_ABCD. SB at 0x201 -> wdata=0xCDCD_CDCD.
- LW at 0x102 -> adelM=1, badvaddrM=0x102, data_req=0, stallM=0. SW at 0x101 -> adesM=1.
- After addr_ok, assert flushM while data_ok is delayed 3 cycles, with a new LW presented -> data_req stays 0 and stallM=1 until data_ok. Then the new LW is issued and the stale data is never returned.
- data_ok arrives with advanceM=0 for 2 cycles -> DONE holds the latched readdataM and stallM=0. No re-issue until advanceM, then IDLE.
